// File: rtl/dmem_region_responder.sv
// rtl/dmem_region_responder.sv - data-memory responder routing CPU loads/stores to low/high banks
module dmem_region_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] SPLIT   = 32'h0000FFFF,
  parameter logic [31:0] HI_SIZE = 32'h00010000,
  parameter int unsigned LO_WAIT = 0,
  parameter int unsigned HI_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              lo_en,
  output logic              lo_we,
  output logic [31:0]       lo_addr,
  output logic [DATA_W-1:0] lo_wdata,
  input  logic [DATA_W-1:0] lo_rdata,
  output logic              hi_en,
  output logic              hi_we,
  output logic [31:0]       hi_addr,
  output logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] hi_rdata
);

  localparam logic [3:0] LO_W = 4'(LO_WAIT);
  localparam logic [3:0] HI_W = 4'(HI_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic              hi_q;
  logic [31:0]       off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic              req_hi;
  logic              oor;

  assign req_hi = (req_addr > SPLIT);
  // off_q already holds the bank-relative offset, so the range check is a plain compare
  assign oor    = hi_q && (off_q >= HI_SIZE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    lo_en      = 1'b0;
    lo_we      = 1'b0;
    lo_addr    = '0;
    lo_wdata   = '0;
    hi_en      = 1'b0;
    hi_we      = 1'b0;
    hi_addr    = '0;
    hi_wdata   = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (!oor && !hi_q) begin
          lo_en    = 1'b1;
          lo_we    = we_q;
          lo_addr  = off_q;
          lo_wdata = wdata_q;
        end
        if (!oor && hi_q) begin
          hi_en    = 1'b1;
          hi_we    = we_q;
          hi_addr  = off_q;
          hi_wdata = wdata_q;
        end
        state_nxt = (oor || we_q) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      hi_q       <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            hi_q    <= req_hi;
            off_q   <= req_hi ? (req_addr - SPLIT) : req_addr;
            wdata_q <= req_wdata;
          end
        end
        S_ISSUE: begin
          resp_rdata <= '0;
          resp_err   <= oor;
          cnt        <= hi_q ? HI_W : LO_W;
        end
        S_WAIT: begin
          if (cnt == 4'd0) resp_rdata <= hi_q ? hi_rdata : lo_rdata;
          else             cnt        <= cnt - 4'd1;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_region_responder.sv
// tb/tb_dmem_region_responder.sv - vector table plus response scoreboard for dmem_region_responder
module tb_dmem_region_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        lo_en, lo_we, hi_en, hi_we;
  logic [31:0] lo_addr, lo_wdata, lo_rdata, hi_addr, hi_wdata, hi_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_region_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .lo_en(lo_en), .lo_we(lo_we), .lo_addr(lo_addr), .lo_wdata(lo_wdata), .lo_rdata(lo_rdata),
    .hi_en(hi_en), .hi_we(hi_we), .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_rdata(hi_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] lo_rd;
    logic [31:0] hi_rd;
    logic        lo_en;
    logic        hi_en;
    logic [31:0] baddr;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  vec_t  vecs[8];
  resp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({tag, "_bank_en_we"}, 64'({lo_en, lo_we, hi_en, hi_we}), 64'd0);
    chk({tag, "_bank_addr_wdata"}, {32'(lo_addr | hi_addr), 32'(lo_wdata | hi_wdata)}, 64'd0);
  endtask

  // Wait (bounded) for resp_valid; returns the edge count after the accept edge.
  task automatic wait_resp(input string tag, output int lat, output int extra_en);
    lat = -1;
    extra_en = 0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (lo_en || hi_en) extra_en++;
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_resp_valid required=resp_valid", tag);
    end
  endtask

  task automatic pop_compare(input string tag);
    resp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb_empty actual=response required=none_expected", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
      chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    int lat, extra;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    lo_rdata = v.lo_rd; hi_rdata = v.hi_rd; resp_ready = 1'b1;
    sbq.push_back('{rdata: v.rdata, err: v.err});
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_en"}, 64'({lo_en, hi_en}), 64'({v.lo_en, v.hi_en}));
    if (v.lo_en)
      chk({tag, "_lo_bus"}, {31'd0, lo_we, lo_addr, lo_wdata}, {31'd0, v.we, v.baddr, v.wdata});
    if (v.hi_en)
      chk({tag, "_hi_bus"}, {31'd0, hi_we, hi_addr, hi_wdata}, {31'd0, v.we, v.baddr, v.wdata});
    wait_resp(tag, lat, extra);
    if (lat > 0) begin
      chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
      chk({tag, "_single_en"}, 64'(extra), 64'd0);
      pop_compare(tag);
      @(posedge clk); #1;
      chk({tag, "_back_idle"}, 64'({resp_valid, req_ready}), 64'b01);
    end else begin
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    int lat, extra;
    //          we    addr           wdata         lo_rd         hi_rd         lo   hi   baddr          rdata         err  lat
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1,1'b0,32'h0000_0010, 32'hDEADBEEF, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h0001_0004, 32'h0000_1234,32'h0,        32'h0,        1'b0,1'b1,32'h0000_0005, 32'h0,        1'b0, 1};
    vecs[2] = '{1'b0, 32'h0000_FFFF, 32'h0,        32'h0000_A5A5,32'h1111_1111,1'b1,1'b0,32'h0000_FFFF, 32'h0000_A5A5,1'b0, 2};
    vecs[3] = '{1'b0, 32'h0001_0000, 32'h0,        32'h2222_2222,32'h0000_5A5A,1'b0,1'b1,32'h0000_0001, 32'h0000_5A5A,1'b0, 4};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        32'h3333_3333,32'h4444_4444,1'b0,1'b0,32'h0,         32'h0,        1'b1, 1};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h0000_CAFE,32'h5555_5555,32'h0,        1'b1,1'b0,32'h0000_0020, 32'h0,        1'b0, 1};
    vecs[6] = '{1'b0, 32'h0001_FFFE, 32'h0,        32'h0,        32'h0000_0077,1'b0,1'b1,32'h0000_FFFF, 32'h0000_0077,1'b0, 4};
    vecs[7] = '{1'b1, 32'h0001_FFFF, 32'hBEEF,     32'h0,        32'h0,        1'b0,1'b0,32'h0,         32'h0,        1'b1, 1};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; lo_rdata = '0; hi_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Backpressure: response held while resp_ready=0; a competing request is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_wdata = '0;
    lo_rdata = 32'h1111_ABCD; resp_ready = 1'b0;
    sbq.push_back('{rdata: 32'h1111_ABCD, err: 1'b0});
    @(posedge clk); #1;
    req_addr = 32'h0001_0100; req_we = 1'b1;
    wait_resp("bp", lat, extra);
    chk("bp_latency", 64'(lat), 64'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      lo_rdata = 32'h0BAD_0BAD;
      chk($sformatf("bp_hold%0d", c), {resp_valid, req_ready, resp_err, resp_rdata}, {1'b1, 1'b0, 1'b0, 32'h1111_ABCD});
      chk($sformatf("bp_no_en%0d", c), 64'({lo_en, hi_en}), 64'd0);
    end
    pop_compare("bp");
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'({resp_valid, req_ready}), 64'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_nothing_queued", 64'({resp_valid, lo_en, hi_en}), 64'd0);
    run_vec(10, vecs[0]);

    // Reset during the WAIT of a high-bank load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0001_0010; hi_rdata = 32'h9999_9999; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid || lo_en || hi_en) extra++;
    end
    chk("rst_mid_no_resp", 64'(extra), 64'd0);
    chk("rst_mid_sb_empty", 64'(sbq.size()), 64'd0);
    run_vec(11, vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
